// File: rtl/matrixmult_feeder.sv
// matrixmult_feeder
//   Holds a 4x4 matrix and a 4-element vector of 16-bit unsigned operands and
//   streams them, one pair every two cycles in row-major order, into a serial
//   matrix-vector multiplier. When the multiplier reports completion, its four
//   results are latched onto pixel_out0..3.
//
// Ports
//   clk, reset           clock (posedge), asynchronous active-low reset
//   wr_en/wr_addr/wr_data operand writes: addr 0-15 matrix (4*row+col),
//                        16-19 vector; ignored while busy or for addr 20-31
//   start                one-cycle job request (honoured only when idle)
//   busy, done, timeout  job in progress, one-cycle completion pulse,
//                        sticky abort flag
//   pixel_out0..3        latched result vector
//   mm_reset, mm_in1, mm_in2, mm_inputs_ready
//                        operand stream to the multiplier (mm_reset active-high)
//   mm_result0..3, mm_done multiplier results and level completion flag
//
// Build option
//   MATRIXMULT_FEEDER_TIMEOUT_EN: when defined, WAIT aborts after WAIT_TIMEOUT
//   cycles without mm_done, setting timeout and pulsing done. Otherwise WAIT
//   waits indefinitely and timeout is tied low.

module matrixmult_feeder #(
    parameter int unsigned WAIT_TIMEOUT = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] pixel_out0,
    output logic [31:0] pixel_out1,
    output logic [31:0] pixel_out2,
    output logic [31:0] pixel_out3,
    output logic        mm_reset,
    output logic [31:0] mm_in1,
    output logic [31:0] mm_in2,
    output logic        mm_inputs_ready,
    input  logic [31:0] mm_result0,
    input  logic [31:0] mm_result1,
    input  logic [31:0] mm_result2,
    input  logic [31:0] mm_result3,
    input  logic        mm_done
);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] ops [20];
    logic [3:0]  pair_idx;   // row-major pair index: row = [3:2], col = [1:0]
    logic        phase;      // 0: pulse cycle, 1: idle gap cycle
    logic        clear_req;  // FSM requests mm_reset for the CLEAR cycle
    logic        capture;
    logic        timeout_hit;

    // Operand store: writable only while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 20; i++) ops[i] <= '0;
        end else if (wr_en && (wr_addr <= 5'd19) && (state == IDLE)) begin
            ops[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pair_idx   <= '0;
            phase      <= 1'b0;
            pixel_out0 <= '0;
            pixel_out1 <= '0;
            pixel_out2 <= '0;
            pixel_out3 <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                pair_idx <= '0;
                phase    <= 1'b0;
            end else if (state == ISSUE) begin
                phase <= ~phase;
                if (phase) pair_idx <= pair_idx + 4'd1;
            end
            if (capture) begin
                pixel_out0 <= mm_result0;
                pixel_out1 <= mm_result1;
                pixel_out2 <= mm_result2;
                pixel_out3 <= mm_result3;
            end
        end
    end

    always_comb begin
        state_next      = state;
        busy            = (state != IDLE);
        done            = (state == DONE);
        clear_req       = 1'b0;
        mm_inputs_ready = 1'b0;
        mm_in1          = '0;
        mm_in2          = '0;
        capture         = 1'b0;
        case (state)
            IDLE:  if (start) state_next = CLEAR;
            CLEAR: begin
                clear_req  = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                // Vector element for column c lives at address 16 + c.
                mm_in1 = {16'd0, ops[{1'b0, pair_idx}]};
                mm_in2 = {16'd0, ops[{3'b100, pair_idx[1:0]}]};
                if (!phase) begin
                    mm_inputs_ready = 1'b1;
                    if (pair_idx == 4'd15) state_next = WAIT;
                end
            end
            WAIT: begin
                if (mm_done) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiplier is also held in reset while this block is.
    assign mm_reset = clear_req | ~reset;

`ifdef MATRIXMULT_FEEDER_TIMEOUT_EN
    localparam int unsigned CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    logic [CW-1:0] wait_cnt;
    logic          timeout_r;

    // wait_cnt counts completed WAIT cycles; the last allowed cycle is
    // WAIT_TIMEOUT-1, so DONE follows exactly WAIT_TIMEOUT cycles after entry.
    assign timeout_hit = (wait_cnt == CW'(WAIT_TIMEOUT - 1));
    assign timeout     = timeout_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + CW'(1) : '0;
            if (state == IDLE && start)
                timeout_r <= 1'b0;
            else if (state == WAIT && !mm_done && timeout_hit)
                timeout_r <= 1'b1;
        end
    end
`else
    logic unused_wait_timeout;
    assign unused_wait_timeout = |WAIT_TIMEOUT;
    assign timeout_hit         = 1'b0;
    assign timeout             = 1'b0;
`endif

endmodule

// File: doc/matrixmult_feeder.md
MATRIXMULT_FEEDER -- requirements
Module: matrixmult_feeder

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 128, giving the maximum WAIT-state cycles before abort (used only with REQ-031).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port wr_en, input, 1, operand write strobe.
REQ-005 SHALL have port wr_addr, input, 5, where 0-15 is the matrix row-major (addr = 4*row + col) and 16-19 is vector elements 0-3.
REQ-006 SHALL have port wr_data, input, 16, operand value (unsigned).
REQ-007 SHALL have port start, input, 1, single-cycle job request.
REQ-008 SHALL have ports busy and done, output, 1 each, for the job in progress and a one-cycle completion pulse.
REQ-009 SHALL have port timeout, output, 1, sticky abort flag.
REQ-010 SHALL have ports pixel_out0..pixel_out3, output, 32 each, latched result vector.
REQ-011 SHALL have ports mm_reset, mm_in1, mm_in2 and mm_inputs_ready, output, widths 1/32/32/1, the operand stream to the serial multiplier; mm_reset is active-high.
REQ-012 SHALL have ports mm_result0..mm_result3 (input, 32 each) and mm_done (input, 1), the multiplier results and its level completion flag.

Function
REQ-013 SHALL store 20 x 16-bit operands; a write with wr_en=1 and wr_addr<=19 SHALL update the operand at the next edge when busy=0.
REQ-014 SHALL ignore writes with wr_addr 20-31, and all writes while busy=1.
REQ-015 SHALL implement the states IDLE, CLEAR, ISSUE, WAIT and DONE.
REQ-016 IDLE: start=1 SHALL move to CLEAR and set busy=1 at the next edge; start SHALL be ignored in every other state.
REQ-017 CLEAR: SHALL hold mm_reset=1 for exactly one cycle, then move to ISSUE.
REQ-018 ISSUE: SHALL emit 16 operand pairs in order (row 0 col 0, row 0 col 1, ..., row 3 col 3), with mm_in1 = matrix[row][col] and mm_in2 = vector[col], each zero-extended to 32 bits.
REQ-019 ISSUE: SHALL pulse mm_inputs_ready for one cycle per pair, with exactly one idle cycle between pulses (a 2-cycle issue interval), and mm_in1/mm_in2 stable during the pulse cycle.
REQ-020 The first mm_inputs_ready pulse SHALL occur in the cycle immediately after CLEAR.
REQ-021 After the 16th pulse the block SHALL move to WAIT with mm_inputs_ready=0.
REQ-022 WAIT: in the first cycle with mm_done=1, SHALL capture mm_result0..3 into pixel_out0..3 and move to DONE.
REQ-023 DONE: SHALL assert done for exactly one cycle, then return to IDLE with busy=0.
REQ-024 pixel_out0..3 SHALL hold their values until the next successful capture; they SHALL NOT change on start.
REQ-025 mm_reset SHALL be 0 in every state except CLEAR, and mm_inputs_ready SHALL be 0 outside ISSUE.
REQ-026 The timeout flag SHALL clear on the start that launches a new job.

Reset
REQ-027 On reset=0, SHALL enter IDLE immediately, independent of clk.
REQ-028 On reset=0, SHALL force busy=0, done=0, timeout=0, mm_inputs_ready=0, mm_in1=0, mm_in2=0, pixel_out0..3=0 and all operands=0.
REQ-029 On reset=0, SHALL drive mm_reset=1 while reset is asserted, so the multiplier is cleared too.
REQ-030 Reset asserted mid-job SHALL abandon the job; no done pulse SHALL follow.

Configuration
REQ-031 With macro MATRIXMULT_FEEDER_TIMEOUT_EN defined, a WAIT-state cycle counter SHALL run; on reaching WAIT_TIMEOUT cycles without mm_done, the block SHALL set timeout=1, leave pixel_out unchanged, pulse done and return to IDLE.
REQ-032 Without the macro, WAIT SHALL wait indefinitely, timeout SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-033 Load matrix rows {1,1,2,3}, {5,6,7,3}, {1,2,3,2}, {4,5,3,5} and vector {2,5,3,1}, then start, with the real matrixmultiplier attached -> pixel_out = 16, 64, 23, 47, one done pulse, busy low afterwards.
REQ-034 Start with a monitor on the multiplier interface -> exactly 16 mm_inputs_ready pulses, 2 cycles apart, and pairs (mm_in1, mm_in2) in row-major order, first pair (1,2), last pair (5,1).
REQ-035 Run two back-to-back jobs, the second with the vector changed to {1,1,1,1} -> mm_reset pulses once per job and second-job pixel_out = 7, 21, 8, 17.
REQ-036 Write to addr 3 with data 9 while busy, and assert start mid-ISSUE -> neither has any effect; the job result is unchanged.
REQ-037 Assert reset during ISSUE at pair 7 -> all outputs zero asynchronously, no done pulse, and a following full job gives correct results.
REQ-038 With the macro defined, tie mm_done=0 and set WAIT_TIMEOUT=8 -> timeout=1 and done pulses 8 cycles after WAIT entry; pixel_out is unchanged.
